// File: rtl/mem_req_ctrl_if.sv
// mem_req_ctrl_if: command, response and memory-port signals of the request controller
interface mem_req_ctrl_if #(
    parameter int WIDTH = 2,
    parameter int PSIZE = 2
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_wr;
    logic [PSIZE-1:0] cmd_addr;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             mem_wr;
    logic             mem_rd;
    logic [PSIZE-1:0] mem_wr_addr;
    logic [PSIZE-1:0] mem_rd_addr;
    logic [WIDTH-1:0] mem_wr_data;
    logic [WIDTH-1:0] mem_rd_data;
    logic [7:0]       wr_cnt;
    logic [7:0]       rd_cnt;

    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_data, rsp_ready, mem_rd_data,
        input  cmd_ready, rsp_valid, rsp_data, mem_wr, mem_rd,
               mem_wr_addr, mem_rd_addr, mem_wr_data, wr_cnt, rd_cnt
    );

    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_data, rsp_ready, mem_rd_data,
        output cmd_ready, rsp_valid, rsp_data, mem_wr, mem_rd,
               mem_wr_addr, mem_rd_addr, mem_wr_data, wr_cnt, rd_cnt
    );
endinterface

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: one-at-a-time command controller in front of a registered, half-swapping memory
module mem_req_ctrl #(
    parameter int WIDTH = 2,
    parameter int PSIZE = 2,
    parameter int DEPTH = 2**PSIZE
) (
    input logic clk,
    input logic rst_n,
    mem_req_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
    localparam logic [PSIZE:0] HALF = (PSIZE+1)'(DEPTH / 2);
    state_t state;
    logic [WIDTH-1:0] wr_word;
    // the memory stores upper-half words with their halves swapped, so pre-swap them to cancel it
    always_comb wr_word = ({1'b0, bus.cmd_addr} >= HALF) ? {bus.cmd_data[WIDTH/2-1:0], bus.cmd_data[WIDTH-1:WIDTH/2]} : bus.cmd_data;
    // controller FSM; every output is a register, strobes live only in ISSUE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            bus.cmd_ready   <= 1'b0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_data    <= '0;
            bus.mem_wr      <= 1'b0;
            bus.mem_rd      <= 1'b0;
            bus.mem_wr_addr <= '0;
            bus.mem_rd_addr <= '0;
            bus.mem_wr_data <= '0;
            bus.wr_cnt      <= '0;
            bus.rd_cnt      <= '0;
        end else begin
            bus.mem_wr <= 1'b0;
            bus.mem_rd <= 1'b0;
            case (state)
                IDLE: begin
                    bus.cmd_ready <= 1'b1;
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        state         <= ISSUE;
                        bus.cmd_ready <= 1'b0;
                        if (bus.cmd_wr) begin
                            bus.mem_wr      <= 1'b1;
                            bus.mem_wr_addr <= bus.cmd_addr;
                            bus.mem_wr_data <= wr_word;
                        end else begin
                            bus.mem_rd      <= 1'b1;
                            bus.mem_rd_addr <= bus.cmd_addr;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.mem_wr) begin
                        state         <= IDLE;
                        bus.cmd_ready <= 1'b1;
                        bus.wr_cnt    <= bus.wr_cnt + 8'd1;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    state         <= RESP;
                    bus.rsp_data  <= bus.mem_rd_data;
                    bus.rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        bus.rd_cnt    <= bus.rd_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: directed and randomized checks of mem_req_ctrl against a swapping memory model
module tb_mem_req_ctrl;
    localparam int WIDTH = 2;
    localparam int PSIZE = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_clr = 1'b1;
    int checks = 0;
    int errors = 0;
    int n_wr;
    int n_rd;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] sb [DEPTH];
    logic [WIDTH-1:0] exp_q [$];

    mem_req_ctrl_if #(.WIDTH(WIDTH), .PSIZE(PSIZE)) bus ();

    mem_req_ctrl #(.WIDTH(WIDTH), .PSIZE(PSIZE), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // registered memory that swaps word halves of the upper address range on write
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            bus.mem_rd_data <= '0;
        end else begin
            if (bus.mem_wr)
                mem[bus.mem_wr_addr] <= (int'(bus.mem_wr_addr) >= DEPTH / 2) ?
                    {bus.mem_wr_data[WIDTH/2-1:0], bus.mem_wr_data[WIDTH-1:WIDTH/2]} : bus.mem_wr_data;
            if (bus.mem_rd) bus.mem_rd_data <= mem[bus.mem_rd_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_clr = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        mem_clr = 1'b0;
        tick();
    endtask

    task automatic send(input logic wr, input logic [PSIZE-1:0] addr, input logic [WIDTH-1:0] data);
        bus.cmd_valid = 1'b1;
        bus.cmd_wr = wr;
        bus.cmd_addr = addr;
        bus.cmd_data = data;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_wr = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_data = '0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 0);
        chk("rst_mem_wr", 32'(bus.mem_wr), 0);
        chk("rst_mem_rd", 32'(bus.mem_rd), 0);
        chk("rst_wr_addr", 32'(bus.mem_wr_addr), 0);
        chk("rst_rd_addr", 32'(bus.mem_rd_addr), 0);
        chk("rst_wr_data", 32'(bus.mem_wr_data), 0);
        chk("rst_wr_cnt", 32'(bus.wr_cnt), 0);
        chk("rst_rd_cnt", 32'(bus.rd_cnt), 0);
        rst_n = 1'b1;
        mem_clr = 1'b0;
        #1;
        chk("ready_before_edge", 32'(bus.cmd_ready), 0);
        tick();
        chk("ready_first_edge", 32'(bus.cmd_ready), 1);

        // write addr 1, data 2'b10: lower half, no swap
        send(1'b1, 2'd1, 2'b10);
        chk("w1_mem_wr", 32'(bus.mem_wr), 1);
        chk("w1_mem_rd", 32'(bus.mem_rd), 0);
        chk("w1_addr", 32'(bus.mem_wr_addr), 1);
        chk("w1_data", 32'(bus.mem_wr_data), 2);
        chk("w1_ready_busy", 32'(bus.cmd_ready), 0);
        tick();
        chk("w1_wr_cnt", 32'(bus.wr_cnt), 1);
        chk("w1_strobe_off", 32'(bus.mem_wr), 0);
        chk("w1_ready_back", 32'(bus.cmd_ready), 1);

        // write addr 3, data 2'b10: upper half, pre-swapped to 2'b01
        send(1'b1, 2'd3, 2'b10);
        chk("w3_data_swap", 32'(bus.mem_wr_data), 1);
        chk("w3_addr", 32'(bus.mem_wr_addr), 3);
        tick();
        chk("w3_wr_cnt", 32'(bus.wr_cnt), 2);

        // read addr 3: acceptance edge, then ISSUE->CAPTURE, then CAPTURE->RESP
        send(1'b0, 2'd3, 2'b00);
        chk("r3_mem_rd", 32'(bus.mem_rd), 1);
        chk("r3_mem_wr", 32'(bus.mem_wr), 0);
        chk("r3_rd_addr", 32'(bus.mem_rd_addr), 3);
        chk("r3_valid_e0", 32'(bus.rsp_valid), 0);
        tick();
        chk("r3_rd_off", 32'(bus.mem_rd), 0);
        chk("r3_valid_e1", 32'(bus.rsp_valid), 0);
        tick();
        chk("r3_valid_e2", 32'(bus.rsp_valid), 1);
        chk("r3_rsp_data", 32'(bus.rsp_data), 2);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("r3_valid_done", 32'(bus.rsp_valid), 0);
        chk("r3_rd_cnt", 32'(bus.rd_cnt), 1);
        chk("r3_ready_back", 32'(bus.cmd_ready), 1);

        // write addr 2, data 2'b01 (sent as 2'b10); read addr 3 must not move
        send(1'b1, 2'd2, 2'b01);
        chk("w2_data_swap", 32'(bus.mem_wr_data), 2);
        chk("w2_rd_addr_hold", 32'(bus.mem_rd_addr), 3);
        tick();
        // read addr 2 with the consumer stalled for 5 cycles
        send(1'b0, 2'd2, 2'b00);
        chk("r2_wr_addr_hold", 32'(bus.mem_wr_addr), 2);
        bus.cmd_valid = 1'b1;
        bus.cmd_wr = 1'b1;
        tick();
        tick();
        chk("r2_valid", 32'(bus.rsp_valid), 1);
        chk("r2_data", 32'(bus.rsp_data), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 32'(bus.rsp_valid), 1);
            chk("stall_data", 32'(bus.rsp_data), 1);
            chk("stall_ready", 32'(bus.cmd_ready), 0);
            chk("stall_mem_wr", 32'(bus.mem_wr), 0);
            chk("stall_rd_cnt", 32'(bus.rd_cnt), 1);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("stall_rd_cnt_inc", 32'(bus.rd_cnt), 2);
        chk("stall_valid_off", 32'(bus.rsp_valid), 0);
        chk("stall_wr_cnt", 32'(bus.wr_cnt), 3);

        // reset during CAPTURE
        send(1'b0, 2'd2, 2'b00);
        tick();
        rst_n = 1'b0;
        #1;
        chk("capt_rst_valid", 32'(bus.rsp_valid), 0);
        chk("capt_rst_mem_rd", 32'(bus.mem_rd), 0);
        chk("capt_rst_rd_cnt", 32'(bus.rd_cnt), 0);
        chk("capt_rst_wr_cnt", 32'(bus.wr_cnt), 0);
        tick();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("capt_post_valid", 32'(bus.rsp_valid), 0);
            chk("capt_post_strobe", 32'(bus.mem_rd | bus.mem_wr), 0);
        end
        bus.rsp_ready = 1'b0;
        chk("capt_post_rd_cnt", 32'(bus.rd_cnt), 0);
        chk("capt_post_ready", 32'(bus.cmd_ready), 1);

        // reset during ISSUE drops the strobe immediately
        send(1'b0, 2'd1, 2'b00);
        chk("iss_mem_rd", 32'(bus.mem_rd), 1);
        rst_n = 1'b0;
        #1;
        chk("iss_rst_mem_rd", 32'(bus.mem_rd), 0);
        chk("iss_rst_rd_addr", 32'(bus.mem_rd_addr), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("iss_post_valid", 32'(bus.rsp_valid), 0);
            chk("iss_post_mem_rd", 32'(bus.mem_rd), 0);
        end

        // reset during RESP discards the pending response
        send(1'b0, 2'd1, 2'b00);
        tick();
        tick();
        chk("resp_valid", 32'(bus.rsp_valid), 1);
        chk("resp_data", 32'(bus.rsp_data), 2);
        rst_n = 1'b0;
        #1;
        chk("resp_rst_valid", 32'(bus.rsp_valid), 0);
        chk("resp_rst_data", 32'(bus.rsp_data), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("resp_post_valid", 32'(bus.rsp_valid), 0);

        // 256 writes wrap the write counter
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send(1'b1, PSIZE'(i), WIDTH'(i));
            tick();
            if (i == 254) chk("wrap_255", 32'(bus.wr_cnt), 255);
        end
        chk("wrap_0", 32'(bus.wr_cnt), 0);
        chk("wrap_rd_cnt", 32'(bus.rd_cnt), 0);

        // random traffic against a logical scoreboard
        do_reset();
        for (int i = 0; i < DEPTH; i++) sb[i] = '0;
        exp_q.delete();
        n_wr = 0;
        n_rd = 0;
        for (int c = 0; c < 10000; c++) begin
            chk("rand_strobe_excl", 32'(bus.mem_wr & bus.mem_rd), 0);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            if (bus.rsp_valid && bus.rsp_ready) begin
                chk("rand_q_nonempty", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("rand_rsp_data", 32'(bus.rsp_data), 32'(exp_q.pop_front()));
                n_rd++;
            end
            bus.cmd_valid = ($urandom_range(0, 3) != 0);
            bus.cmd_wr = 1'($urandom);
            bus.cmd_addr = PSIZE'($urandom);
            bus.cmd_data = WIDTH'($urandom);
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (bus.cmd_wr) begin
                    sb[bus.cmd_addr] = bus.cmd_data;
                    n_wr++;
                end else begin
                    exp_q.push_back(sb[bus.cmd_addr]);
                end
            end
            tick();
        end
        bus.cmd_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.rsp_ready = 1'b1;
            if (bus.rsp_valid) begin
                chk("drain_q_nonempty", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("drain_rsp_data", 32'(bus.rsp_data), 32'(exp_q.pop_front()));
                n_rd++;
            end
            tick();
        end
        chk("rand_q_empty", 32'(exp_q.size()), 0);
        chk("rand_wr_cnt", 32'(bus.wr_cnt), 32'(n_wr % 256));
        chk("rand_rd_cnt", 32'(bus.rd_cnt), 32'(n_rd % 256));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
